// File: rtl/jtkcpu_intsched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : jtkcpu_intsched                                               |
// | Brief    : KCPU interrupt scheduler - pin sync, NMI edge latch, priority, |
// |            reset vector and SYNC/CWAI wait sequencing.                   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module jtkcpu_intsched #(
    parameter int SYNC_STAGES = 2,
    parameter bit NMI_ARM     = 1'b0
) (
    input  logic       rst,
    input  logic       clk,
    input  logic       cen,
    input  logic       irq_n,
    input  logic       firq_n,
    input  logic       nmi_n,
    input  logic [7:0] cc,
    input  logic       ni,
    input  logic       up_s,
    input  logic       wait_sync,
    input  logic       wait_cwai,
    input  logic       ack,
    output logic       int_req,
    output logic [3:0] intvec,
    output logic       int_firq,
    output logic       halt_wait,
    output logic       nmi_armed
);

    localparam logic [1:0] c_ST_RSTV = 2'd0;
    localparam logic [1:0] c_ST_IDLE = 2'd1;
    localparam logic [1:0] c_ST_PEND = 2'd2;
    localparam logic [1:0] c_ST_WAIT = 2'd3;

    localparam logic [3:0] c_VEC_RST  = 4'hE;
    localparam logic [3:0] c_VEC_NMI  = 4'hC;
    localparam logic [3:0] c_VEC_IRQ  = 4'h8;
    localparam logic [3:0] c_VEC_FIRQ = 4'h6;

    // Each stage carries {nmi, firq, irq}; free-running, independent of cen.
    logic [SYNC_STAGES-1:0][2:0] r_sync;
    logic [1:0]                  r_state;
    logic                        r_nmi_prev;
    logic                        r_nmi_lat;
    logic                        r_wait_cwai;

    logic       w_irq_s;
    logic       w_firq_s;
    logic       w_nmi_s;
    logic       w_nmi_edge;
    logic       w_any_low;
    logic       w_cand;
    logic [3:0] w_vec;
    logic       w_firq;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync[0] <= {nmi_n, firq_n, irq_n};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_irq_s    = r_sync[SYNC_STAGES-1][0];
    assign w_firq_s   = r_sync[SYNC_STAGES-1][1];
    assign w_nmi_s    = r_sync[SYNC_STAGES-1][2];
    assign w_nmi_edge = r_nmi_prev & ~w_nmi_s & nmi_armed;
    assign w_any_low  = ~w_irq_s | ~w_firq_s | ~w_nmi_s | r_nmi_lat;

    always_comb begin
        w_cand = 1'b0;
        w_vec  = c_VEC_IRQ;
        w_firq = 1'b0;
        if (r_nmi_lat) begin
            w_cand = 1'b1;
            w_vec  = c_VEC_NMI;
        end else if (~w_firq_s & ~cc[6]) begin
            w_cand = 1'b1;
            w_vec  = c_VEC_FIRQ;
            w_firq = 1'b1;
        end else if (~w_irq_s & ~cc[4]) begin
            w_cand = 1'b1;
            w_vec  = c_VEC_IRQ;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_RSTV;
            int_req     <= 1'b0;
            intvec      <= c_VEC_RST;
            int_firq    <= 1'b0;
            halt_wait   <= 1'b0;
            nmi_armed   <= NMI_ARM;
            r_nmi_lat   <= 1'b0;
            r_nmi_prev  <= 1'b1;
            r_wait_cwai <= 1'b0;
        end else if (cen) begin
            r_nmi_prev <= w_nmi_s;
            if (up_s) nmi_armed <= 1'b1;
            // A fresh edge wins over the acknowledge of the previous NMI.
            if (w_nmi_edge)
                r_nmi_lat <= 1'b1;
            else if (r_state == c_ST_PEND && ack && intvec == c_VEC_NMI)
                r_nmi_lat <= 1'b0;

            case (r_state)
                c_ST_RSTV: begin
                    intvec <= c_VEC_RST;
                    if (ack) begin
                        r_state <= c_ST_IDLE;
                        int_req <= 1'b0;
                    end else begin
                        int_req <= 1'b1;
                    end
                end
                c_ST_IDLE: begin
                    if (wait_sync || wait_cwai) begin
                        r_state     <= c_ST_WAIT;
                        halt_wait   <= 1'b1;
                        r_wait_cwai <= wait_cwai;
                    end else if (ni && w_cand) begin
                        r_state  <= c_ST_PEND;
                        int_req  <= 1'b1;
                        intvec   <= w_vec;
                        int_firq <= w_firq;
                    end
                end
                c_ST_PEND: begin
                    if (ack) begin
                        r_state <= c_ST_IDLE;
                        int_req <= 1'b0;
                    end
                end
                c_ST_WAIT: begin
                    if (w_cand) begin
                        r_state   <= c_ST_PEND;
                        int_req   <= 1'b1;
                        intvec    <= w_vec;
                        int_firq  <= w_firq;
                        halt_wait <= 1'b0;
                    end else if (!r_wait_cwai && w_any_low) begin
                        // SYNC released by a masked line: resume without a request.
                        r_state   <= c_ST_IDLE;
                        halt_wait <= 1'b0;
                    end
                end
                default: r_state <= c_ST_RSTV;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jtkcpu_intsched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_jtkcpu_intsched                                            |
// | Brief    : Directed bench with request scoreboard for jtkcpu_intsched.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_jtkcpu_intsched;

    logic       rst = 1'b1;
    logic       clk = 1'b0;
    logic       cen = 1'b1;
    logic       irq_n = 1'b1;
    logic       firq_n = 1'b1;
    logic       nmi_n = 1'b1;
    logic [7:0] cc = 8'h50;
    logic       ni = 1'b0;
    logic       up_s = 1'b0;
    logic       wait_sync = 1'b0;
    logic       wait_cwai = 1'b0;
    logic       ack = 1'b0;
    logic       int_req;
    logic [3:0] intvec;
    logic       int_firq;
    logic       halt_wait;
    logic       nmi_armed;

    int checks = 0;
    int errors = 0;
    logic [4:0] exp_q[$];

    jtkcpu_intsched #(.SYNC_STAGES(2), .NMI_ARM(1'b0)) dut (
        .rst(rst), .clk(clk), .cen(cen), .irq_n(irq_n), .firq_n(firq_n),
        .nmi_n(nmi_n), .cc(cc), .ni(ni), .up_s(up_s), .wait_sync(wait_sync),
        .wait_cwai(wait_cwai), .ack(ack), .int_req(int_req), .intvec(intvec),
        .int_firq(int_firq), .halt_wait(halt_wait), .nmi_armed(nmi_armed)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_req(input string name, input int max);
        bit seen = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (int_req === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: got no int_req within %0d cycles, expected int_req=1", name, max);
        end
    endtask

    task automatic wait_halt_clear(input string name, input int max);
        bit seen = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (halt_wait === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: got halt_wait=1 after %0d cycles, expected 0", name, max);
        end
    endtask

    task automatic ack_pulse(input string name);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        @(negedge clk);
        chk(name, int_req, 0);
    endtask

    // Monitor: every new request is matched against the next expected {intvec, int_firq}.
    initial begin
        logic prev = 1'b0;
        logic [4:0] exp;
        forever begin
            @(negedge clk);
            if (int_req === 1'b1 && prev !== 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_req: got intvec=%0h firq=%0b, expected no request",
                             intvec, int_firq);
                end else begin
                    exp = exp_q.pop_front();
                    if ({intvec, int_firq} !== exp) begin
                        errors++;
                        $display("FAIL req_vector: got intvec=%0h firq=%0b expected intvec=%0h firq=%0b",
                                 intvec, int_firq, exp[4:1], exp[0]);
                    end
                end
            end
            prev = int_req;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state and reset vector request
        repeat (3) tick();
        @(negedge clk);
        chk("rst_int_req", int_req, 0);
        chk("rst_intvec", intvec, 4'hE);
        chk("rst_int_firq", int_firq, 0);
        chk("rst_halt", halt_wait, 0);
        chk("rst_armed", nmi_armed, 0);
        exp_q.push_back({4'hE, 1'b0});
        rst = 1'b0;
        wait_req("rstv_req", 4);
        chk("rstv_intvec", intvec, 4'hE);
        ack_pulse("rstv_ack");

        // NMI ignored until S is loaded
        cc = 8'h00;
        nmi_n = 1'b0;
        ni = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        chk("nmi_unarmed", int_req, 0);
        nmi_n = 1'b1;
        repeat (4) tick();
        up_s = 1'b1;
        tick();
        up_s = 1'b0;
        @(negedge clk);
        chk("nmi_armed", nmi_armed, 1);
        exp_q.push_back({4'hC, 1'b0});
        nmi_n = 1'b0;
        wait_req("nmi_req", 8);
        ni = 1'b0;
        ack_pulse("nmi_ack");
        ni = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        chk("nmi_cleared", int_req, 0);
        ni = 1'b0;
        nmi_n = 1'b1;
        repeat (4) tick();

        // Priority and masking
        firq_n = 1'b0;
        irq_n = 1'b0;
        repeat (4) tick();
        exp_q.push_back({4'h6, 1'b1});
        ni = 1'b1;
        wait_req("prio_firq", 4);
        ni = 1'b0;
        ack_pulse("prio_firq_ack");
        cc = 8'h40;
        exp_q.push_back({4'h8, 1'b0});
        ni = 1'b1;
        wait_req("prio_irq", 4);
        ni = 1'b0;
        ack_pulse("prio_irq_ack");
        cc = 8'h50;
        ni = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        chk("prio_masked", int_req, 0);
        ni = 1'b0;
        firq_n = 1'b1;
        irq_n = 1'b1;
        repeat (4) tick();

        // SYNC released by a masked IRQ: resumes with no request
        cc = 8'h10;
        ni = 1'b1;
        wait_sync = 1'b1;
        tick();
        wait_sync = 1'b0;
        @(negedge clk);
        chk("sync_halt", halt_wait, 1);
        repeat (3) tick();
        @(negedge clk);
        chk("sync_hold", halt_wait, 1);
        irq_n = 1'b0;
        wait_halt_clear("sync_release", 6);
        chk("sync_noreq", int_req, 0);
        repeat (3) tick();
        @(negedge clk);
        chk("sync_resume", int_req, 0);
        ni = 1'b0;
        irq_n = 1'b1;
        repeat (4) tick();

        // CWAI ignores masked IRQ, leaves on unmasked one
        wait_cwai = 1'b1;
        tick();
        wait_cwai = 1'b0;
        irq_n = 1'b0;
        repeat (6) tick();
        @(negedge clk);
        chk("cwai_hold", halt_wait, 1);
        chk("cwai_noreq", int_req, 0);
        exp_q.push_back({4'h8, 1'b0});
        cc = 8'h00;
        wait_req("cwai_irq", 3);
        chk("cwai_exit", halt_wait, 0);
        ack_pulse("cwai_ack");
        irq_n = 1'b1;
        repeat (4) tick();

        // New NMI edge latched on the very cen that acknowledges the previous NMI
        exp_q.push_back({4'hC, 1'b0});
        nmi_n = 1'b0;
        ni = 1'b1;
        wait_req("nmi2_req", 8);
        ni = 1'b0;
        nmi_n = 1'b1;
        repeat (4) tick();
        nmi_n = 1'b0;
        tick();
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        @(negedge clk);
        chk("nmi_race_ack", int_req, 0);
        exp_q.push_back({4'hC, 1'b0});
        ni = 1'b1;
        wait_req("nmi_relatch", 4);
        ni = 1'b0;
        ack_pulse("nmi_relatch_ack");
        nmi_n = 1'b1;
        repeat (4) tick();

        // cen low freezes the scheduler
        cen = 1'b0;
        firq_n = 1'b0;
        ni = 1'b1;
        repeat (10) tick();
        @(negedge clk);
        chk("cen_noreq", int_req, 0);
        exp_q.push_back({4'h6, 1'b1});
        cen = 1'b1;
        wait_req("cen_firq", 3);
        ni = 1'b0;
        ack_pulse("cen_ack");
        firq_n = 1'b1;
        repeat (4) tick();

        // Reset in the middle of a pending request
        irq_n = 1'b0;
        repeat (4) tick();
        exp_q.push_back({4'h8, 1'b0});
        ni = 1'b1;
        wait_req("pre_rst_req", 4);
        ni = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("mid_rst_req", int_req, 0);
        chk("mid_rst_vec", intvec, 4'hE);
        chk("mid_rst_armed", nmi_armed, 0);
        irq_n = 1'b1;
        exp_q.push_back({4'hE, 1'b0});
        rst = 1'b0;
        wait_req("rst_again", 4);
        ack_pulse("rst_again_ack");

        repeat (2) tick();
        @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
